// File: rtl/bitwise_logic_pkg.sv
// Shared constants for the bitwise logic pipe: op encodings, buffer depth
// and the fill-state encoding of the 2-entry output buffer.
package bitwise_logic_pkg;
  localparam int OP_W      = 3;
  localparam int BUF_DEPTH = 2;

  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_OR    = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'd5;
  localparam logic [OP_W-1:0] OP_PASSA = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;
endpackage

// File: rtl/logic_op_comb.sv
// Combinational bitwise function unit: selects one of eight functions of
// A and B and flags an all-zero result.
module logic_op_comb
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);
  logic [WIDTH-1:0] w_res;

  always_comb begin
    w_res = '0;
    case (i_op)
      OP_AND:   w_res = i_a & i_b;
      OP_OR:    w_res = i_a | i_b;
      OP_XOR:   w_res = i_a ^ i_b;
      OP_NOR:   w_res = ~(i_a | i_b);
      OP_NAND:  w_res = ~(i_a & i_b);
      OP_NOTA:  w_res = ~i_a;
      OP_PASSA: w_res = i_a;
      OP_XNOR:  w_res = ~(i_a ^ i_b);
      default:  w_res = '0;
    endcase
  end

  assign o_result = w_res;
  assign o_zero   = ~|w_res;
endmodule

// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit with a 2-entry output FIFO and valid/ready
// handshakes on both sides; all outputs come from flops.
module bitwise_logic_pipe
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [OP_W-1:0]  out_op
);
  logic [WIDTH-1:0] r_res  [BUF_DEPTH];
  logic             r_zero [BUF_DEPTH];
  logic [OP_W-1:0]  r_op   [BUF_DEPTH];
  logic             r_wptr, r_rptr;
  logic             r_in_ready;
  buf_state_e       r_state, w_state_nxt;

  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_push, w_pop;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_result (w_res),
    .o_zero   (w_zero)
  );

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = out_valid && out_ready;

  // in_ready is registered from the next state, so it never sees same-cycle out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (r_state != ST_EMPTY);
    in_ready   = r_in_ready;
    out_result = r_res[r_rptr];
    out_zero   = r_zero[r_rptr];
    out_op     = r_op[r_rptr];
  end

  // Zero flags reset high so the cleared (all-zero) entries stay self-consistent
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_res[i]  <= '0;
        r_zero[i] <= 1'b1;
        r_op[i]   <= '0;
      end
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_res[r_wptr]  <= w_res;
        r_zero[r_wptr] <= w_zero;
        r_op[r_wptr]   <= in_op;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
    end
  end
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench: queue-based model of the 2-entry buffer checked every
// cycle, plus literal expectations from hand-computed cases.
module tb_bitwise_logic_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [2:0]  in_op, out_op;
  logic [31:0] in_a, in_b, out_result;

  logic        v1_valid, v1_ready, v1_ovalid, v1_oready, v1_zero;
  logic [2:0]  v1_op, v1_oop;
  logic        v1_a, v1_b, v1_res;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_op(out_op)
  );

  bitwise_logic_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1_valid), .in_ready(v1_ready),
    .in_op(v1_op), .in_a(v1_a), .in_b(v1_b), .out_valid(v1_ovalid),
    .out_ready(v1_oready), .out_result(v1_res), .out_zero(v1_zero),
    .out_op(v1_oop)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  op;
  } ent_t;

  ent_t q[$];
  int   n_pass = 0, n_tot = 0, n_pop = 0;
  bit   chk_en = 1'b0;
  bit   m_push, m_pop;

  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~a;
      3'd6: return a;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO of at most two results, updated at each edge
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      m_pop  = (q.size() > 0) && out_ready;
      m_push = in_valid && (q.size() < 2);
      if (m_pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (m_push) q.push_back({ref_fn(in_op, in_a, in_b), in_op});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        check("model_result", out_result, q[0].res);
        check("model_zero", {31'd0, out_zero}, {31'd0, q[0].res == 32'd0});
        check("model_op", {29'd0, out_op}, {29'd0, q[0].op});
      end
    end
  end

  logic [31:0] sweep_exp [8];
  int          p0;

  initial begin
    sweep_exp[0] = 32'hF000F000; sweep_exp[1] = 32'hFFF0FFF0;
    sweep_exp[2] = 32'h0FF00FF0; sweep_exp[3] = 32'h000F000F;
    sweep_exp[4] = 32'h0FFF0FFF; sweep_exp[5] = 32'h0F0F0F0F;
    sweep_exp[6] = 32'hF0F0F0F0; sweep_exp[7] = 32'hF00FF00F;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    v1_valid = 1'b0; v1_oready = 1'b0; v1_op = '0; v1_a = 1'b0; v1_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", out_result, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd1);
    check("rst_op", {29'd0, out_op}, 32'd0);

    // NOTA of 21, and NAND 1,1 on the 1-bit instance
    in_op = 3'd5; in_a = 32'd21; in_b = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
    v1_op = 3'd4; v1_a = 1'b1; v1_b = 1'b1; v1_valid = 1'b1; v1_oready = 1'b1;
    @(negedge clk);
    check("nota_result", out_result, 32'hFFFFFFEA);
    check("nota_zero", {31'd0, out_zero}, 32'd0);
    check("nota_op", {29'd0, out_op}, 32'd5);
    check("w1_valid", {31'd0, v1_ovalid}, 32'd1);
    check("w1_result", {31'd0, v1_res}, 32'd0);
    check("w1_zero", {31'd0, v1_zero}, 32'd1);
    check("w1_op", {29'd0, v1_oop}, 32'd4);
    in_valid = 1'b0; v1_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i); in_a = 32'hF0F0F0F0; in_b = 32'hFF00FF00; in_valid = 1'b1;
      @(negedge clk);
      check("sweep_result", out_result, sweep_exp[i]);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: two accepts fill, third waits until a pop frees a slot
    out_ready = 1'b0; in_valid = 1'b1;
    in_op = 3'd0; in_a = 32'd1; in_b = 32'd1;
    @(negedge clk);
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    in_op = 3'd1; in_a = 32'd0; in_b = 32'd0;
    @(negedge clk);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    in_op = 3'd2; in_a = 32'd5; in_b = 32'd5;
    repeat (2) @(negedge clk);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_result", out_result, 32'd1);
    check("bp_hold_zero", {31'd0, out_zero}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_pop2_result", out_result, 32'd0);
    check("bp_pop2_zero", {31'd0, out_zero}, 32'd1);
    check("bp_pop2_op", {29'd0, out_op}, 32'd1);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("bp_pop3_op", {29'd0, out_op}, 32'd2);
    check("bp_pop3_zero", {31'd0, out_zero}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while full with in_valid high
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd6; in_a = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_zero", {31'd0, out_zero}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // 100 back-to-back random ops
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_op = 3'($urandom_range(0, 7));
      in_a = $urandom; in_b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_count", n_pop - p0, 32'd100);

    // Random valid/ready mix
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
      in_op = 3'($urandom_range(0, 7));
      in_a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      in_b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
